mem_request_arbiter: RTL and testbench
======================================

Name: mem_request_arbiter

Overview:
- Parametrised successor to the single-cycle request logic: accepts load/store requests from NCH requesters (icache/dcache or per-core ports) and serialises them onto one memory port.
- Each request is held until its per-channel hit pulse.
- Uses round-robin fairness, a halt drain, and a sticky watchdog error for stalled memory.
- Sits between the datapath/cache request side and the memory controller.

Parameters:
NCH, 2, number of requesting channels (>=1)
AW, 32, address width
DW, 32, data width
TIMEOUT, 255, mem_wait cycles tolerated per transaction before err sets (>=1)

Ports:
CLK  in  1  clock, rising edge
Rst  in  1  asynchronous reset, active-high
halt  in  1  stop granting; drain in-flight transaction
ch_ren  in  NCH  per-channel read request
ch_wen  in  NCH  per-channel write request
ch_addr  in  NCH*AW  channel i at [i*AW +: AW]
ch_wdata  in  NCH*DW  channel i at [i*DW +: DW]
ch_hit  out  NCH  one-cycle completion pulse, channel i
ch_rdata  out  DW  read data, valid with ch_hit
mem_ren  out  1  memory read strobe (registered)
mem_wen  out  1  memory write strobe (registered)
mem_addr  out  AW  registered address
mem_wdata  out  DW  registered write data
mem_rdata  in  DW  memory read data
mem_wait  in  1  memory not done this cycle
halted  out  1  drained and stopped
err  out  1  sticky watchdog error

Behaviour:
- Clock and reset: one clock CLK; reset Rst is asynchronous and active-high.
- Reset (async, any state, including mid-transaction):
  - state=IDLE, rr_ptr=0, grant=0, wait_cnt=0.
  - mem_ren=mem_wen=0, mem_addr=mem_wdata=0, halted=0, err=0.
  - ch_hit=0.
- State machine:
  - IDLE to BUSY: not halt and any(ch_ren|ch_wen). The granted channel is the first requesting index found scanning rr_ptr, rr_ptr+1, ... mod NCH. On that edge, latch grant and register mem_addr/mem_wdata from the granted channel. If ch_wen[grant]=1 then mem_wen=1, mem_ren=0 (write wins when both asserted); else mem_ren=1.
  - IDLE to HALTED: halt=1, whether or not requests are pending.
  - BUSY, mem_wait=1: hold all mem_* outputs and increment wait_cnt (saturating). err sets when wait_cnt reaches TIMEOUT; the transaction is not aborted.
  - BUSY, mem_wait=0: ch_hit[grant]=1 combinationally in this cycle, with ch_rdata=mem_rdata. On the edge: mem_ren=mem_wen=0, wait_cnt=0, rr_ptr=(grant+1) mod NCH. Next state is HALTED if halt=1 in this cycle, else IDLE.
  - HALTED: sticky until Rst. halted=1 registered; mem_* strobes stay 0; no ch_hit.
- Latency: request in IDLE at edge k gives mem strobe from k+1; hit in the first cycle with mem_wait=0. Minimum 2 cycles, request to hit.
- No back-to-back grants: at least one IDLE cycle separates transactions.
- A requester must deassert on the edge at which it sees ch_hit. A request still asserted in IDLE is treated as a new request.
- Granted channel drops its request while BUSY: the transaction still completes and ch_hit still pulses. Latched values are used; ch_* inputs are not re-sampled.
- halt asserted while BUSY: the current transaction completes normally, then HALTED. halt in the same cycle as an IDLE request: no grant.
- ch_rdata=mem_rdata at all times; it is meaningful only with ch_hit.
- ch_hit is all-zero outside BUSY.
- rr_ptr wraps NCH-1 to 0.
- NCH=1: rr_ptr is constant 0.
- wait_cnt has width $clog2(TIMEOUT+1) and saturates at TIMEOUT.

Test Plan:
- Single read: NCH=2, ch_ren[0]=1, addr 0x100, mem_wait low one cycle after strobe with mem_rdata=0xDEADBEEF. Expect mem_ren=1 and mem_addr=0x100 one cycle after request, ch_hit[0] pulse with ch_rdata=0xDEADBEEF, and rr_ptr=1.
- Round-robin: both channels request continuously (reissuing after hit), mem_wait=0. Expect grants in order 0,1,0,1 with exactly one IDLE cycle between hits, and no channel granted twice in a row.
- Write priority: ch_ren[1]=ch_wen[1]=1, wdata 0x12345678. Expect mem_wen=1, mem_ren=0, mem_wdata=0x12345678, and ch_hit[1].
- Halt drain: halt asserted on the 2nd BUSY cycle with mem_wait=1 for 3 cycles. Expect the transaction to complete with a hit, then halted=1, and no further strobes despite ch_ren=2'b11.
- Watchdog: TIMEOUT=4, mem_wait held 6 cycles. Expect err=1 after 4 wait cycles, hit after release, and err still 1 through the next transaction until Rst.
- Async reset mid-BUSY: Rst asserted between edges. Expect mem_ren/mem_wen/ch_hit/halted/err=0 immediately. After release, expect the first grant to go to channel 0.

Source files
------------

// File: rtl/mem_request_arbiter.sv
// Round-robin arbiter that serialises per-channel load/store requests onto a
// single registered memory port, with halt drain and a sticky stall watchdog.
module mem_request_arbiter #(
    parameter int NCH     = 2,
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              CLK,
    input  logic              Rst,
    input  logic              halt,
    input  logic [NCH-1:0]    ch_ren,
    input  logic [NCH-1:0]    ch_wen,
    input  logic [NCH*AW-1:0] ch_addr,
    input  logic [NCH*DW-1:0] ch_wdata,
    output logic [NCH-1:0]    ch_hit,
    output logic [DW-1:0]     ch_rdata,
    output logic              mem_ren,
    output logic              mem_wen,
    output logic [AW-1:0]     mem_addr,
    output logic [DW-1:0]     mem_wdata,
    input  logic [DW-1:0]     mem_rdata,
    input  logic              mem_wait,
    output logic              halted,
    output logic              err
);

    localparam int GW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TMAX = CW'(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_BUSY   = 2'd1,
        S_HALTED = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [GW-1:0]   r_rr_ptr;
    logic [GW-1:0]   r_grant;
    logic [CW-1:0]   r_wait_cnt;
    logic            r_mem_ren;
    logic            r_mem_wen;
    logic [AW-1:0]   r_mem_addr;
    logic [DW-1:0]   r_mem_wdata;
    logic            r_halted;
    logic            r_err;

    logic [NCH-1:0]  w_req;
    logic [GW:0]     w_pick_res;
    logic            w_found;
    logic [GW-1:0]   w_pick;
    logic [NCH-1:0]  w_hit;
    logic            w_grant_now;
    logic            w_done_now;

    // Search from ptr upward (mod NCH); lowest offset wins, so iterate downward.
    function automatic logic [GW:0] rr_pick(input logic [NCH-1:0] req,
                                            input logic [GW-1:0]  ptr);
        logic [GW:0] res;
        int          idx;
        res = '0;
        for (int k = NCH - 1; k >= 0; k--) begin
            idx = int'(ptr) + k;
            if (idx >= NCH) begin
                idx = idx - NCH;
            end else begin
                idx = idx;
            end
            if (req[idx]) begin
                res = {1'b1, GW'(idx)};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    function automatic logic [GW-1:0] ptr_after(input logic [GW-1:0] g);
        logic [GW-1:0] nxt;
        if (g >= GW'(NCH - 1)) begin
            nxt = '0;
        end else begin
            nxt = g + GW'(1);
        end
        return nxt;
    endfunction

    // Round-robin request selection
    always_comb begin
        w_req      = ch_ren | ch_wen;
        w_pick_res = rr_pick(w_req, r_rr_ptr);
        w_found    = w_pick_res[GW];
        w_pick     = w_pick_res[GW-1:0];
    end

    // Next-state logic and per-cycle event decode
    always_comb begin
        w_state_nxt = r_state;
        w_grant_now = 1'b0;
        w_done_now  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (halt) begin
                    w_state_nxt = S_HALTED;
                end else if (w_found) begin
                    w_state_nxt = S_BUSY;
                    w_grant_now = 1'b1;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_BUSY: begin
                if (!mem_wait) begin
                    w_done_now  = 1'b1;
                    w_state_nxt = halt ? S_HALTED : S_IDLE;
                end else begin
                    w_state_nxt = S_BUSY;
                end
            end
            S_HALTED: begin
                w_state_nxt = S_HALTED;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Completion pulse is combinational so the requester sees it in the done cycle
    always_comb begin
        w_hit = '0;
        if (w_done_now) begin
            w_hit[r_grant] = 1'b1;
        end else begin
            w_hit = '0;
        end
    end

    // Control state: FSM, grant, round-robin pointer, watchdog, halt/err flags
    always_ff @(posedge CLK or posedge Rst) begin
        if (Rst) begin
            r_state    <= S_IDLE;
            r_rr_ptr   <= '0;
            r_grant    <= '0;
            r_wait_cnt <= '0;
            r_halted   <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_grant_now) begin
                r_grant    <= w_pick;
                r_wait_cnt <= '0;
            end else if (w_done_now) begin
                r_wait_cnt <= '0;
                r_rr_ptr   <= ptr_after(r_grant);
            end else if (r_state == S_BUSY) begin
                // Stalled memory: count saturating; err latches, transaction continues
                if (r_wait_cnt != TMAX) begin
                    r_wait_cnt <= r_wait_cnt + CW'(1);
                end else begin
                    r_wait_cnt <= r_wait_cnt;
                end
                if (r_wait_cnt >= TMAX - CW'(1)) begin
                    r_err <= 1'b1;
                end else begin
                    r_err <= r_err;
                end
            end else begin
                r_wait_cnt <= r_wait_cnt;
            end
            if (w_state_nxt == S_HALTED) begin
                r_halted <= 1'b1;
            end else begin
                r_halted <= r_halted;
            end
        end
    end

    // Registered memory port: captured at grant, strobes dropped at completion
    always_ff @(posedge CLK or posedge Rst) begin
        if (Rst) begin
            r_mem_ren   <= 1'b0;
            r_mem_wen   <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else if (w_grant_now) begin
            r_mem_addr  <= ch_addr[int'(w_pick)*AW +: AW];
            r_mem_wdata <= ch_wdata[int'(w_pick)*DW +: DW];
            r_mem_wen   <= ch_wen[w_pick];
            r_mem_ren   <= ~ch_wen[w_pick];
        end else if (w_done_now || (r_state != S_BUSY)) begin
            r_mem_ren   <= 1'b0;
            r_mem_wen   <= 1'b0;
        end else begin
            r_mem_ren   <= r_mem_ren;
            r_mem_wen   <= r_mem_wen;
        end
    end

    assign ch_hit    = w_hit;
    assign ch_rdata  = mem_rdata;
    assign mem_ren   = r_mem_ren;
    assign mem_wen   = r_mem_wen;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign halted    = r_halted;
    assign err       = r_err;

endmodule

// File: tb/tb_mem_request_arbiter.sv
// Directed self-checking bench for mem_request_arbiter (NCH=2, TIMEOUT=4).
module tb_mem_request_arbiter;

    localparam int NCH = 2;
    localparam int AW  = 32;
    localparam int DW  = 32;

    logic              CLK;
    logic              Rst;
    logic              halt;
    logic [NCH-1:0]    ch_ren;
    logic [NCH-1:0]    ch_wen;
    logic [NCH*AW-1:0] ch_addr;
    logic [NCH*DW-1:0] ch_wdata;
    logic [NCH-1:0]    ch_hit;
    logic [DW-1:0]     ch_rdata;
    logic              mem_ren;
    logic              mem_wen;
    logic [AW-1:0]     mem_addr;
    logic [DW-1:0]     mem_wdata;
    logic [DW-1:0]     mem_rdata;
    logic              mem_wait;
    logic              halted;
    logic              err;

    int total;
    int bad;

    mem_request_arbiter #(.NCH(NCH), .AW(AW), .DW(DW), .TIMEOUT(4)) dut (
        .CLK(CLK), .Rst(Rst), .halt(halt),
        .ch_ren(ch_ren), .ch_wen(ch_wen), .ch_addr(ch_addr), .ch_wdata(ch_wdata),
        .ch_hit(ch_hit), .ch_rdata(ch_rdata),
        .mem_ren(mem_ren), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_wait(mem_wait),
        .halted(halted), .err(err)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic cyc;
        @(posedge CLK);
        #2;
    endtask

    task automatic settle;
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        Rst       = 1'b1;
        halt      = 1'b0;
        ch_ren    = 2'b00;
        ch_wen    = 2'b00;
        ch_addr   = '0;
        ch_wdata  = '0;
        mem_rdata = 32'h0;
        mem_wait  = 1'b0;

        // reset state
        cyc; settle;
        chk("rst_mem_ren", 64'(mem_ren), 64'd0);
        chk("rst_mem_wen", 64'(mem_wen), 64'd0);
        chk("rst_mem_addr", 64'(mem_addr), 64'd0);
        chk("rst_halted", 64'(halted), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_hit", 64'(ch_hit), 64'd0);
        cyc; Rst = 1'b0;
        cyc;

        // single read on channel 0
        ch_ren = 2'b01; ch_addr[31:0] = 32'h100; mem_wait = 1'b1;
        settle; chk("rd_idle_hit", 64'(ch_hit), 64'd0);
        cyc; settle;
        chk("rd_mem_ren", 64'(mem_ren), 64'd1);
        chk("rd_mem_wen", 64'(mem_wen), 64'd0);
        chk("rd_mem_addr", 64'(mem_addr), 64'h100);
        chk("rd_wait_hit", 64'(ch_hit), 64'd0);
        ch_ren = 2'b00;
        cyc; mem_wait = 1'b0; mem_rdata = 32'hDEADBEEF; settle;
        chk("rd_hit", 64'(ch_hit), 64'b01);
        chk("rd_rdata", 64'(ch_rdata), 64'hDEADBEEF);
        cyc; settle;
        chk("rd_after_ren", 64'(mem_ren), 64'd0);
        chk("rd_after_hit", 64'(ch_hit), 64'd0);
        chk("rd_rr_ptr", 64'(dut.r_rr_ptr), 64'd1);

        // round robin, both channels always requesting, no wait states
        ch_addr = {32'h300, 32'h200}; ch_ren = 2'b11;
        for (int i = 0; i < 4; i++) begin
            cyc; settle;
            chk("rr_hit", 64'(ch_hit), (i % 2 == 0) ? 64'b10 : 64'b01);
            chk("rr_addr", 64'(mem_addr), (i % 2 == 0) ? 64'h300 : 64'h200);
            chk("rr_ren", 64'(mem_ren), 64'd1);
            cyc; settle;
            chk("rr_gap_hit", 64'(ch_hit), 64'd0);
            chk("rr_gap_ren", 64'(mem_ren), 64'd0);
        end
        ch_ren = 2'b00;

        // write wins over read on channel 1
        ch_ren = 2'b10; ch_wen = 2'b10; ch_addr[63:32] = 32'h400;
        ch_wdata[63:32] = 32'h12345678; mem_wait = 1'b1;
        cyc; settle;
        chk("wr_mem_wen", 64'(mem_wen), 64'd1);
        chk("wr_mem_ren", 64'(mem_ren), 64'd0);
        chk("wr_wdata", 64'(mem_wdata), 64'h12345678);
        chk("wr_addr", 64'(mem_addr), 64'h400);
        ch_ren = 2'b00; ch_wen = 2'b00; mem_wait = 1'b0; settle;
        chk("wr_hit", 64'(ch_hit), 64'b10);
        cyc; settle;
        chk("wr_after_wen", 64'(mem_wen), 64'd0);
        chk("wr_rr_ptr", 64'(dut.r_rr_ptr), 64'd0);

        // halt raised during the 2nd busy cycle drains the transaction
        ch_ren = 2'b01; ch_addr[31:0] = 32'h500; mem_wait = 1'b1;
        cyc;
        cyc; halt = 1'b1; settle;
        chk("hd_busy2_hit", 64'(ch_hit), 64'd0);
        cyc; settle;
        chk("hd_busy3_ren", 64'(mem_ren), 64'd1);
        chk("hd_busy3_halted", 64'(halted), 64'd0);
        cyc; mem_wait = 1'b0; settle;
        chk("hd_hit", 64'(ch_hit), 64'b01);
        ch_ren = 2'b11;
        cyc; halt = 1'b0; settle;
        chk("hd_halted", 64'(halted), 64'd1);
        for (int i = 0; i < 3; i++) begin
            cyc; settle;
            chk("hd_no_ren", 64'(mem_ren), 64'd0);
            chk("hd_no_wen", 64'(mem_wen), 64'd0);
            chk("hd_no_hit", 64'(ch_hit), 64'd0);
            chk("hd_sticky", 64'(halted), 64'd1);
        end
        chk("hd_err", 64'(err), 64'd0);
        Rst = 1'b1; settle;
        chk("hd_rst_halted", 64'(halted), 64'd0);
        cyc; Rst = 1'b0; ch_ren = 2'b00;

        // halt together with an idle request: no grant
        halt = 1'b1; ch_ren = 2'b01;
        cyc; settle;
        chk("hi_no_ren", 64'(mem_ren), 64'd0);
        chk("hi_halted", 64'(halted), 64'd1);
        Rst = 1'b1; halt = 1'b0; ch_ren = 2'b00;
        cyc; Rst = 1'b0;

        // watchdog: 6 wait cycles with TIMEOUT=4
        ch_ren = 2'b10; ch_addr[63:32] = 32'h600; mem_wait = 1'b1;
        cyc; settle;
        chk("wd_addr", 64'(mem_addr), 64'h600);
        ch_ren = 2'b00;
        for (int i = 1; i <= 6; i++) begin
            cyc; settle;
            chk("wd_err", 64'(err), (i >= 4) ? 64'd1 : 64'd0);
            chk("wd_ren_hold", 64'(mem_ren), 64'd1);
        end
        mem_wait = 1'b0; settle;
        chk("wd_hit", 64'(ch_hit), 64'b10);
        cyc; settle;
        chk("wd_err_idle", 64'(err), 64'd1);
        ch_ren = 2'b01; ch_addr[31:0] = 32'h700;
        cyc; settle;
        chk("wd2_hit", 64'(ch_hit), 64'b01);
        chk("wd2_addr", 64'(mem_addr), 64'h700);
        chk("wd2_err", 64'(err), 64'd1);
        ch_ren = 2'b00;
        cyc;

        // async reset in the middle of a busy cycle
        ch_ren = 2'b10; mem_wait = 1'b1;
        cyc; settle;
        chk("ar_busy_ren", 64'(mem_ren), 64'd1);
        ch_ren = 2'b00;
        #1; Rst = 1'b1; #1;
        chk("ar_ren", 64'(mem_ren), 64'd0);
        chk("ar_wen", 64'(mem_wen), 64'd0);
        chk("ar_hit", 64'(ch_hit), 64'd0);
        chk("ar_halted", 64'(halted), 64'd0);
        chk("ar_err", 64'(err), 64'd0);
        #1; Rst = 1'b0; ch_ren = 2'b11; mem_wait = 1'b0;
        ch_addr = {32'h900, 32'h800};
        cyc; settle;
        chk("ar_first_hit", 64'(ch_hit), 64'b01);
        chk("ar_first_addr", 64'(mem_addr), 64'h800);
        ch_ren = 2'b00;
        cyc;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
